// File: rtl/motor_seq_pkg.sv
// Shared types and default widths for the motor move sequencer.
package motor_seq_pkg;

  localparam int POS_W_DEF = 20;
  localparam int DIV_W_DEF = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic signed [POS_W_DEF-1:0] target;
    logic        [DIV_W_DEF-1:0] div;
  } cmd_t;

endpackage

// File: rtl/motor_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with occupancy and flush.
module motor_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/motor_move_sequencer.sv
// Absolute-position move scheduler driving a step/dir generator; stops exactly on target.
// Define MOTOR_SEQ_RAMP_EN for a linear acceleration ramp from ramp_start_div down to the cruise divider.
module motor_move_sequencer
  import motor_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int POS_W      = POS_W_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int MIN_DIV    = 2
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [POS_W-1:0]              cmd_target,
  input  logic [DIV_W-1:0]              cmd_div,
  input  logic                          abort,
  input  logic                          step_in,
  input  logic [POS_W-1:0]              cur_position,
`ifdef MOTOR_SEQ_RAMP_EN
  input  logic [DIV_W-1:0]              ramp_start_div,
  input  logic [DIV_W-1:0]              ramp_inc,
`endif
  output logic [DIV_W-1:0]              div_out,
  output logic                          dir_out,
  output logic                          step_ena,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int               CW        = POS_W + DIV_W;
  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

  seq_state_t         state_q, state_d;
  logic [POS_W-1:0]   target_q, target_d;
  logic [DIV_W-1:0]   cruise_q, cruise_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               dir_q, dir_d;
  logic               ena_q, ena_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic signed [POS_W:0] delta;
  logic [CW-1:0]      fifo_rdata;
  logic [DIV_W-1:0]   head_div;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;

`ifdef MOTOR_SEQ_RAMP_EN
  logic step_prev_q, step_prev_d;
`endif

  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !abort;
  assign head_div  = fifo_rdata[DIV_W-1:0];

  motor_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CW)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .flush (abort),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({cmd_target, cmd_div}),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign div_out   = div_q;
  assign dir_out   = dir_q;
  assign step_ena  = ena_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

  // One extra bit so opposite-extreme positions cannot overflow the difference.
  assign delta = $signed({target_q[POS_W-1], target_q}) - $signed({cur_position[POS_W-1], cur_position});

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cruise_d  = cruise_q;
    div_d     = div_q;
    dir_d     = dir_q;
    ena_d     = ena_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
`ifdef MOTOR_SEQ_RAMP_EN
    step_prev_d = step_in;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          target_d = fifo_rdata[CW-1:DIV_W];
          cruise_d = (head_div < MIN_DIV_V) ? MIN_DIV_V : head_div;
          state_d  = LOAD;
        end
      end
      LOAD: begin
`ifdef MOTOR_SEQ_RAMP_EN
        div_d = (ramp_start_div > cruise_q) ? ramp_start_div : cruise_q;
`else
        div_d = cruise_q;
`endif
        if (delta == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          dir_d   = !delta[POS_W];
          ena_d   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MOTOR_SEQ_RAMP_EN
        if (step_in && !step_prev_q)
          div_d = ((div_q - cruise_q) >= ramp_inc) ? (div_q - ramp_inc) : cruise_q;
`endif
        if (delta == '0) begin
          ena_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (!step_in && (dir_q == delta[POS_W])) begin
          // Generator position jumped past us; turn around between pulses.
          dir_d = !delta[POS_W];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      ena_d     = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      target_q  <= '0;
      cruise_q  <= MIN_DIV_V;
      div_q     <= MIN_DIV_V;
      dir_q     <= 1'b1;
      ena_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef MOTOR_SEQ_RAMP_EN
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cruise_q  <= cruise_d;
      div_q     <= div_d;
      dir_q     <= dir_d;
      ena_q     <= ena_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
`ifdef MOTOR_SEQ_RAMP_EN
      step_prev_q <= step_prev_d;
`endif
    end
  end

endmodule

// File: tb/tb_motor_move_sequencer.sv
// Directed bench for motor_move_sequencer with a behavioural step/dir generator model.
// The ramp section is compiled only with MOTOR_SEQ_RAMP_EN.
module tb_motor_move_sequencer;

  localparam int POS_W = 20;
  localparam int DIV_W = 13;

  logic              CLK = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [POS_W-1:0]  cmd_target;
  logic [DIV_W-1:0]  cmd_div;
  logic              abort;
  logic              step_in;
  logic signed [POS_W-1:0] cur_position;
  logic [DIV_W-1:0]  ramp_start_div;
  logic [DIV_W-1:0]  ramp_inc;
  logic [DIV_W-1:0]  div_out;
  logic              dir_out, step_ena, busy, done, aborted;
  logic [2:0]        fifo_level;

  int checks   = 0;
  int failures = 0;

  motor_move_sequencer dut (
    .CLK            (CLK),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_target     (cmd_target),
    .cmd_div        (cmd_div),
    .abort          (abort),
    .step_in        (step_in),
    .cur_position   (cur_position),
`ifdef MOTOR_SEQ_RAMP_EN
    .ramp_start_div (ramp_start_div),
    .ramp_inc       (ramp_inc),
`endif
    .div_out        (div_out),
    .dir_out        (dir_out),
    .step_ena       (step_ena),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .fifo_level     (fifo_level)
  );

  always #5 CLK = ~CLK;

  // Generator: samples step_ena once per divider period, counter idles while disabled.
  int gen_cnt;
  always @(posedge CLK) begin
    if (reset) begin
      gen_cnt      <= 0;
      step_in      <= 1'b0;
      cur_position <= '0;
    end else begin
      step_in <= 1'b0;
      if (!step_ena) gen_cnt <= 0;
      else if (gen_cnt >= int'(div_out) - 1) begin
        gen_cnt      <= 0;
        step_in      <= 1'b1;
        cur_position <= dir_out ? cur_position + 1'b1 : cur_position - 1'b1;
      end else gen_cnt <= gen_cnt + 1;
    end
  end

  int step_cnt = 0, done_cnt = 0, abort_cnt = 0, cyc = 0, ena_rise_cyc = 0;
  logic ena_prev = 1'b0;
  int step_cyc [0:511];
  int done_pos [0:31];
  always @(posedge CLK) begin
    if (step_in) begin
      if (step_cnt < 512) step_cyc[step_cnt] = cyc;
      step_cnt++;
    end
    if (done) begin
      if (done_cnt < 32) done_pos[done_cnt] = cur_position;
      done_cnt++;
    end
    if (aborted) abort_cnt++;
    if (step_ena && !ena_prev) ena_rise_cyc = cyc;
    ena_prev = step_ena;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic push(input int tgt, input int dv);
    cmd_valid  = 1'b1;
    cmd_target = tgt[POS_W-1:0];
    cmd_div    = dv[DIV_W-1:0];
    @(negedge CLK);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_dones(input int want, input int budget);
    int n = 0;
    while (done_cnt < want && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("done_wait", done_cnt >= want, 1);
  endtask

  int s0, d0, n;
  int tq [4] = '{190, 195, 192, 198};

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_div = '0; abort = 1'b0;
    ramp_start_div = '0; ramp_inc = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ena", step_ena, 0);
    chk("rst_div", div_out, 2);
    chk("rst_dir", dir_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abrt", aborted, 0);
    chk("rst_rdy", cmd_ready, 1);
    chk("rst_lvl", fifo_level, 0);
    reset = 1'b0;

    // Move 0 -> 10, including push-to-enable latency.
    push(10, 100);
    chk("t1_ena_c1", step_ena, 0);
    chk("t1_lvl", fifo_level, 1);
    @(negedge CLK);
    chk("t1_ena_c2", step_ena, 0);
    chk("t1_busy", busy, 1);
    @(negedge CLK);
    chk("t1_ena_c3", step_ena, 1);
    chk("t1_dir", dir_out, 1);
    chk("t1_div", div_out, 100);
    wait_dones(1, 1200);
    chk("t1_steps", step_cnt, 10);
    chk("t1_pos", cur_position, 10);
    @(negedge CLK);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_ena_off", step_ena, 0);

    // Move 10 -> -5 (negative direction).
    push(-5, 50);
    wait_dones(2, 1000);
    chk("t2_dir", dir_out, 0);
    chk("t2_steps", step_cnt, 25);
    chk("t2_pos", cur_position, -5);

    // Zero-length move: done two cycles after pop, no step.
    s0 = step_cnt;
    push(-5, 30);
    chk("t3_done_c1", done, 0);
    @(negedge CLK);
    chk("t3_done_c2", done, 0);
    @(negedge CLK);
    chk("t3_done_c3", done, 1);
    chk("t3_ena", step_ena, 0);
    @(negedge CLK);
    chk("t3_steps", step_cnt - s0, 0);

    // Fill the FIFO behind a long move; fifth push refused.
    d0 = done_cnt;
    push(200, 10);
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_target = tq[i][POS_W-1:0]; cmd_div = 13'd4;
      @(negedge CLK);
    end
    cmd_target = '0;
    chk("t4_rdy", cmd_ready, 0);
    chk("t4_lvl", fifo_level, 4);
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("t4_lvl_hold", fifo_level, 4);
    wait_dones(d0 + 5, 4000);
    chk("t4_pos0", done_pos[d0], 200);
    for (int i = 0; i < 4; i++) chk("t4_order", done_pos[d0 + 1 + i], tq[i]);
    repeat (60) @(negedge CLK);
    chk("t4_ndone", done_cnt - d0, 5);
    chk("t4_idle", busy, 0);
    chk("t4_pos", cur_position, 198);

    // Abort after 3 of 20 steps, with a queued command and a same-cycle push.
    d0 = done_cnt;
    push(218, 20);
    repeat (3) @(negedge CLK);
    push(0, 5);
    chk("t5_lvl1", fifo_level, 1);
    n = 0;
    while (cur_position != 201 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("t5_reach", cur_position, 201);
    cmd_valid = 1'b1; cmd_target = 20'd50; cmd_div = 13'd5; abort = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0; abort = 1'b0;
    chk("t5_ena", step_ena, 0);
    chk("t5_abrt", aborted, 1);
    chk("t5_lvl", fifo_level, 0);
    chk("t5_busy", busy, 0);
    @(negedge CLK);
    chk("t5_abrt_pulse", aborted, 0);
    repeat (100) @(negedge CLK);
    chk("t5_pos", cur_position, 201);
    chk("t5_nodone", done_cnt - d0, 0);
    chk("t5_abrt_cnt", abort_cnt, 1);

    // Divider clamp.
    d0 = done_cnt;
    push(205, 0);
    repeat (2) @(negedge CLK);
    chk("t6_div", div_out, 2);
    chk("t6_ena", step_ena, 1);
    wait_dones(d0 + 1, 200);
    chk("t6_pos", cur_position, 205);

`ifdef MOTOR_SEQ_RAMP_EN
    ramp_start_div = 13'd400; ramp_inc = 13'd100;
    d0 = done_cnt;
    s0 = step_cnt;
    push(210, 100);
    wait_dones(d0 + 1, 2000);
    chk("ramp_p0", step_cyc[s0] - ena_rise_cyc, 400);
    chk("ramp_p1", step_cyc[s0 + 1] - step_cyc[s0], 300);
    chk("ramp_p2", step_cyc[s0 + 2] - step_cyc[s0 + 1], 200);
    chk("ramp_p3", step_cyc[s0 + 3] - step_cyc[s0 + 2], 100);
    chk("ramp_p4", step_cyc[s0 + 4] - step_cyc[s0 + 3], 100);
    chk("ramp_pos", cur_position, 210);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_move_sequencer.md
Name: motor_move_sequencer

Overview:
Command-driven move scheduler that sits in front of the existing step/dir generator.
- Accepts absolute-position move commands through a small FIFO.
- For each command, drives the generator's divider, moveDir and stepClockEna.
- Watches the generator's step and cur_position outputs and stops exactly on target.
- Pulses done, then pops the next command.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
POS_W, 20, signed position width; matches the generator's cur_position.
DIV_W, 13, divider width; matches the generator's divider.
MIN_DIV, 2, smallest divider forwarded; smaller commanded values are clamped to this.

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO not full
cmd_target  in  POS_W  signed absolute target position
cmd_div  in  DIV_W  cruise divider for this move
abort  in  1  single-cycle: stop the current move and flush the FIFO
step_in  in  1  generator step output
cur_position  in  POS_W  generator position
div_out  out  DIV_W  to generator divider
dir_out  out  1  to generator moveDir; 1 = increasing position
step_ena  out  1  to generator stepClockEna
busy  out  1  state != IDLE or FIFO not empty
done  out  1  one-cycle pulse when a move completes on target
aborted  out  1  one-cycle pulse when abort takes effect
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values:
  - FIFO empty; state IDLE.
  - div_out = MIN_DIV; dir_out = 1; step_ena = 0.
  - done, aborted, busy = 0; cmd_ready = 1.
  - Reset mid-move drops step_ena on the next edge; pending commands are lost.
- FIFO push:
  - Occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered.
  - Push while full is ignored.
  - Simultaneous push and pop while full is allowed only if the pop happens first in the same cycle; occupancy stays unchanged.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: if the FIFO is not empty, pop and go to LOAD.
- LOAD (1 cycle):
  - Latch target.
  - div_out = max(cmd_div, MIN_DIV).
  - delta = target - cur_position, computed at POS_W+1 bits signed to avoid overflow.
  - delta == 0: go to DONE with step_ena held 0, i.e. a zero-length move.
  - Otherwise: dir_out = (delta > 0), step_ena = 1, go to RUN.
- RUN:
  - Each cycle compare cur_position with target.
  - On equality: step_ena <= 0 and go to DONE.
  - Because the generator samples stepClockEna only once per divider period and div >= MIN_DIV >= 2, no extra step is issued after equality.
  - dir_out is frozen during RUN.
  - If cur_position moves away from target (external reset of the generator), recompute dir_out only while step_in is low, and keep running.
- DONE:
  - done = 1 for one cycle.
  - Then go to IDLE; with a non-empty FIFO this is back-to-back, 2 cycles between moves.
- abort (any state):
  - Next cycle: step_ena = 0, FIFO flushed, state IDLE, aborted = 1 for one cycle.
  - No done pulse is issued.
  - Abort and push in the same cycle: the pushed command is discarded.
- Latency: cmd push to step_ena high is 3 cycles when idle (FIFO write, IDLE pop, LOAD).
- Width rules: all position arithmetic is signed two's complement; no wrap of target is permitted (2^19 range).

Optional Feature:
- Macro: MOTOR_SEQ_RAMP_EN.
- With the macro defined:
  - Add ports ramp_start_div (DIV_W) and ramp_inc (DIV_W).
  - In LOAD, div_out = max(ramp_start_div, cruise).
  - On each step_in rising edge in RUN, div_out decrements by ramp_inc, saturating at cruise div.
  - Deceleration is not modelled.
- Without the macro:
  - div_out = cruise div for the whole move.
  - Ports are absent.

Decomposition:
- Package motor_seq_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - POS_W/DIV_W defaults;
  - the command struct {target, div}.
- One sub-module, motor_cmd_fifo: synchronous FIFO with level, full, empty and flush.

Test Plan:
1. After reset, push target 10, div 100; model generator at position 0 -> dir_out = 1, exactly 10 step pulses, cur_position = 10, done pulses once, step_ena = 0 afterward.
2. From position 10, push target -5, div 50 -> dir_out = 0, 15 steps, final position -5, done.
3. Push target equal to the current position -> no step, done 2 cycles after pop.
4. Push 5 commands while idle-blocked with FIFO_DEPTH = 4 -> 5th push is refused (cmd_ready = 0), fifo_level = 4; all 4 execute in order with done after each.
5. Abort after 3 of 20 steps -> step_ena = 0 next cycle, aborted pulse, FIFO level 0, no done, position 3 or 4 and no further steps.
6. cmd_div = 0 -> div_out = 2 (clamp). With MOTOR_SEQ_RAMP_EN, start 400, inc 100, cruise 100 -> successive periods 400, 300, 200, 100, 100.
